// File: rtl/i2s_transmitter_if.sv
// Sample handshake between an audio producer and the I2S transmitter.
// The producer offers a left/right pair; the transmitter accepts it when ready.
interface i2s_transmitter_if #(
  parameter int AUDIO_BIT_WIDTH = 24
) ();
  logic [AUDIO_BIT_WIDTH-1:0] sample_left;
  logic [AUDIO_BIT_WIDTH-1:0] sample_right;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_transmitter.sv
// Standard I2S serializer with a one-pair holding buffer; frames never stall,
// repeating the last pair and pulsing underrun when no new pair is waiting.
module i2s_transmitter #(
  parameter int AUDIO_BIT_WIDTH = 24,
  parameter int BCLK_DIVIDE     = 6,
  parameter int SLOT_WIDTH      = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  i2s_transmitter_if.slave bus,
  output logic             o_bclk,
  output logic             o_lrclk,
  output logic             o_sdata,
  output logic             o_underrun
);

  localparam int DIV_W = (BCLK_DIVIDE > 2) ? $clog2(BCLK_DIVIDE) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam int IDX_W = (AUDIO_BIT_WIDTH > 2) ? $clog2(AUDIO_BIT_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIVIDE - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIVIDE / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);

  logic [DIV_W-1:0]           r_divCnt;
  logic [BIT_W-1:0]           r_bitCnt;
  logic                       r_bclk;
  logic                       r_lrclk;
  logic                       r_sdata;
  logic                       r_underrun;
  logic                       r_bufFull;
  logic                       r_ready;
  logic [AUDIO_BIT_WIDTH-1:0] r_bufLeft;
  logic [AUDIO_BIT_WIDTH-1:0] r_bufRight;
  logic [AUDIO_BIT_WIDTH-1:0] r_frameLeft;
  logic [AUDIO_BIT_WIDTH-1:0] r_frameRight;

  logic             w_evtE;
  logic             w_load;
  logic             w_handshake;
  logic             w_fullNext;
  logic [DIV_W-1:0] w_divNext;
  logic [BIT_W-1:0] w_bitNext;
  logic             w_lrclkNext;
  logic             w_sdataNext;
  logic [IDX_W-1:0] w_leftIdx;
  logic [IDX_W-1:0] w_rightIdx;

  assign w_evtE      = (r_divCnt == DIV_LAST);
  assign w_load      = w_evtE && (r_bitCnt == BIT_LAST);
  assign w_handshake = bus.sample_valid && r_ready;
  assign w_divNext   = w_evtE ? '0 : r_divCnt + 1'b1;

  // Serial outputs are precomputed from the bit count about to be entered so
  // the flops present them in the cycle right after the bclk falling edge.
  always_comb begin
    w_bitNext   = r_bitCnt;
    w_sdataNext = 1'b0;
    if (w_evtE) begin
      w_bitNext = (r_bitCnt == BIT_LAST) ? '0 : r_bitCnt + 1'b1;
    end
    w_lrclkNext = (int'(w_bitNext) >= SLOT_WIDTH);
    w_leftIdx   = IDX_W'(AUDIO_BIT_WIDTH - int'(w_bitNext));
    w_rightIdx  = IDX_W'(AUDIO_BIT_WIDTH + SLOT_WIDTH - int'(w_bitNext));
    if (int'(w_bitNext) >= 1 && int'(w_bitNext) <= AUDIO_BIT_WIDTH) begin
      w_sdataNext = r_frameLeft[w_leftIdx];
    end else if (int'(w_bitNext) >= SLOT_WIDTH + 1 &&
                 int'(w_bitNext) <= SLOT_WIDTH + AUDIO_BIT_WIDTH) begin
      w_sdataNext = r_frameRight[w_rightIdx];
    end
  end

  // A frame load drains the buffer; an accept can only happen while it is empty.
  always_comb begin
    w_fullNext = r_bufFull;
    if (w_load && r_bufFull) begin
      w_fullNext = 1'b0;
    end else if (w_handshake) begin
      w_fullNext = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_divCnt     <= '0;
      r_bitCnt     <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
      r_underrun   <= 1'b0;
      r_bufFull    <= 1'b0;
      r_ready      <= 1'b1;
      r_bufLeft    <= '0;
      r_bufRight   <= '0;
      r_frameLeft  <= '0;
      r_frameRight <= '0;
    end else begin
      r_divCnt   <= w_divNext;
      r_bclk     <= (w_divNext >= DIV_HALF);
      r_underrun <= w_load && !r_bufFull;
      r_bufFull  <= w_fullNext;
      r_ready    <= !w_fullNext;
      if (w_evtE) begin
        r_bitCnt <= w_bitNext;
        r_lrclk  <= w_lrclkNext;
        r_sdata  <= w_sdataNext;
      end
      if (w_load && r_bufFull) begin
        r_frameLeft  <= r_bufLeft;
        r_frameRight <= r_bufRight;
      end
      if (w_handshake) begin
        r_bufLeft  <= bus.sample_left;
        r_bufRight <= bus.sample_right;
      end
    end
  end

  assign bus.sample_ready = r_ready;
  assign o_bclk           = r_bclk;
  assign o_lrclk          = r_lrclk;
  assign o_sdata          = r_sdata;
  assign o_underrun       = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomized bench for i2s_transmitter: a frame-arithmetic reference model
// predicts every output cycle by cycle from the elapsed cycle count.
module tb_i2s_transmitter;

  localparam int ABW   = 24;
  localparam int DIV   = 6;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT * DIV;

  logic clock = 1'b0;
  logic reset;
  logic bclk, lrclk, sdata, underrun;

  always #5 clock = ~clock;

  i2s_transmitter_if #(.AUDIO_BIT_WIDTH(ABW)) sif ();

  i2s_transmitter #(
    .AUDIO_BIT_WIDTH(ABW),
    .BCLK_DIVIDE    (DIV),
    .SLOT_WIDTH     (SLOT)
  ) dut (
    .i_clock   (clock),
    .i_reset   (reset),
    .bus       (sif),
    .o_bclk    (bclk),
    .o_lrclk   (lrclk),
    .o_sdata   (sdata),
    .o_underrun(underrun)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: t counts clock edges since reset release.
  int           t;
  logic [ABW-1:0] frameL, frameR, pendL, pendR;
  bit           pendFull;
  bit           expUnderrun;

  task automatic modelReset();
    t           = 0;
    frameL      = '0;
    frameR      = '0;
    pendL       = '0;
    pendR       = '0;
    pendFull    = 1'b0;
    expUnderrun = 1'b0;
  endtask

  function automatic logic expSdata(int n);
    if (n >= 1 && n <= ABW) return frameL[ABW-n];
    if (n >= SLOT + 1 && n <= SLOT + ABW) return frameR[ABW-(n-SLOT)];
    return 1'b0;
  endfunction

  task automatic checkOutput(string tag, logic observed, logic expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0b expected=%0b t=%0d", tag, observed, expected, t);
    end
  endtask

  task automatic checkAll();
    int bitIdx;
    bitIdx = (t / DIV) % (2 * SLOT);
    checkOutput("bclk",     bclk,             (t % DIV) >= DIV / 2);
    checkOutput("lrclk",    lrclk,            bitIdx >= SLOT);
    checkOutput("sdata",    sdata,            expSdata(bitIdx));
    checkOutput("underrun", underrun,         expUnderrun);
    checkOutput("ready",    sif.sample_ready, !pendFull);
  endtask

  // Called at a negedge: drive, check, advance one clock, return at next negedge.
  task automatic applyStimulus(bit valid, logic [ABW-1:0] l, logic [ABW-1:0] r);
    bit hs;
    sif.sample_valid = valid;
    sif.sample_left  = l;
    sif.sample_right = r;
    checkAll();
    hs = valid && !pendFull;
    @(posedge clock);
    t++;
    expUnderrun = 1'b0;
    if (t % FRAME == 0) begin
      if (pendFull) begin
        frameL   = pendL;
        frameR   = pendR;
        pendFull = 1'b0;
      end else begin
        expUnderrun = 1'b1;
      end
    end
    if (hs) begin
      pendFull = 1'b1;
      pendL    = l;
      pendR    = r;
    end
    @(negedge clock);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, ABW'($urandom), ABW'($urandom));
    end
  endtask

  initial begin
    bit reached;
    reset            = 1'b1;
    sif.sample_valid = 1'b0;
    sif.sample_left  = '0;
    sif.sample_right = '0;
    modelReset();

    // Reset values.
    #1;
    checkAll();
    @(negedge clock);
    checkAll();
    @(negedge clock);
    reset = 1'b0;
    modelReset();

    // Directed pair before the first frame load, then hold valid low.
    idle(50);
    applyStimulus(1'b1, 24'h800001, 24'h7FFFFE);
    idle(3 * FRAME);

    // Random sparse traffic.
    for (int i = 0; i < 4 * FRAME; i++) begin
      applyStimulus(($urandom % 4) == 0, ABW'($urandom), ABW'($urandom));
    end

    // Valid held high continuously.
    for (int i = 0; i < 3 * FRAME; i++) begin
      applyStimulus(1'b1, ABW'($urandom), ABW'($urandom));
    end

    // Handshake in the same cycle as a frame load with the buffer empty.
    reached = 1'b0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      if (!pendFull && ((t + 1) % FRAME == 0)) reached = 1'b1;
      else idle(1);
    end
    checkOutput("sync_to_load", reached, 1'b1);
    applyStimulus(1'b1, ABW'($urandom), ABW'($urandom));
    checkOutput("same_cycle_underrun", underrun, 1'b1);
    idle(FRAME + 20);

    // Reset asserted mid-frame at bit 40.
    reached = 1'b0;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      if (((t / DIV) % (2 * SLOT)) == 40) reached = 1'b1;
      else applyStimulus(($urandom % 8) == 0, ABW'($urandom), ABW'($urandom));
    end
    checkOutput("sync_to_bit40", reached, 1'b1);
    sif.sample_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_bclk",     bclk,             1'b0);
    checkOutput("rst_lrclk",    lrclk,            1'b0);
    checkOutput("rst_sdata",    sdata,            1'b0);
    checkOutput("rst_underrun", underrun,         1'b0);
    checkOutput("rst_ready",    sif.sample_ready, 1'b1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    idle(2 * FRAME + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
